// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point multiplier scheduler.
//   - Q-format widths for the default Q8.8 x Q8.8 -> Q16.16 datapath
//   - operand/product typedefs for that default format
//   - scheduler FSM state enum
//   - rr_pick: round-robin grant search used by the arbiter
package fxp_pkg;

    localparam int FXP_N1  = 8;
    localparam int FXP_M1  = 8;
    localparam int FXP_N2  = 8;
    localparam int FXP_M2  = 8;
    localparam int FXP_A_W = FXP_N1 + FXP_M1;
    localparam int FXP_B_W = FXP_N2 + FXP_M2;
    localparam int FXP_P_W = FXP_A_W + FXP_B_W;

    // Upper bound on requesters; rr_pick works on vectors of this size.
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef logic signed [FXP_A_W-1:0] fxp_a_t;
    typedef logic signed [FXP_B_W-1:0] fxp_b_t;
    typedef logic signed [FXP_P_W-1:0] fxp_prod_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    // First set bit of valid, searching upward from ptr and wrapping at n_req.
    // Returns ptr when nothing is valid; callers qualify with |valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int                 ptr,
                                   input int                 n_req);
        int  grant;
        int  idx;
        logic found;
        grant = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n_req) begin
                idx = ptr + k;
                if (idx >= n_req) idx = idx - n_req;
                if (!found && valid[idx[MAX_ID_W-1:0]]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fixed_point_multiplication.sv
// Full-precision signed fixed-point multiplier.
//   a : signed Q(N1).(M1)
//   b : signed Q(N2).(M2)
//   p : signed Q(N1+N2).(M1+M2), exact product (no rounding or saturation)
// Purely combinational.
module fixed_point_multiplication #(
    parameter int N1 = 8,
    parameter int M1 = 8,
    parameter int N2 = 8,
    parameter int M2 = 8
) (
    input  logic signed [N1+M1-1:0]       a,
    input  logic signed [N2+M2-1:0]       b,
    output logic signed [N1+N2+M1+M2-1:0] p
);

    localparam int A_W = N1 + M1;
    localparam int B_W = N2 + M2;

    // Sign-extend both operands to the product width so the multiply is
    // exact in that width.
    assign p = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});

endmodule

// File: rtl/fxp_mul_scheduler.sv
// Round-robin scheduler sharing one signed fixed-point multiplier between
// N_REQ requesters.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot or 0)
//   req_a, req_b        : packed operands, requester i at slice i
//   rsp_valid/rsp_ready : product handshake
//   rsp_data, rsp_id    : signed product and the issuing requester's index
//   busy                : FSM not idle
//   op_count            : completed responses, wraps at 16 bits
// Flow: IDLE (grant + capture) -> MUL (register product) -> RESP (hold until taken).
module fxp_mul_scheduler
    import fxp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int N1    = 8,
    parameter int M1    = 8,
    parameter int N2    = 8,
    parameter int M2    = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*(N1+M1)-1:0]   req_a,
    input  logic [N_REQ*(N2+M2)-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N1+N2+M1+M2-1:0]     rsp_data,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       busy,
    output logic [15:0]                op_count
);

    localparam int A_W = N1 + M1;
    localparam int B_W = N2 + M2;
    localparam int P_W = A_W + B_W;

    sched_state_e          state_q, state_d;
    logic [ID_W-1:0]       ptr_q;
    logic [ID_W-1:0]       id_q;
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;
    logic [15:0]           cnt_q;

    logic [ID_W-1:0]       grant;
    logic                  any_req;
    logic                  op_hs;
    logic                  rsp_hs;
    logic [A_W-1:0]        a_sel;
    logic [B_W-1:0]        b_sel;
    logic signed [P_W-1:0] prod;

    assign any_req = |req_valid;
    assign grant   = ID_W'(rr_pick(MAX_REQ'(req_valid), int'(ptr_q), N_REQ));
    assign a_sel   = req_a[grant*A_W +: A_W];
    assign b_sel   = req_b[grant*B_W +: B_W];

    fixed_point_multiplication #(
        .N1 (N1),
        .M1 (M1),
        .N2 (N2),
        .M2 (M2)
    ) u_mul (
        .a (a_q),
        .b (b_q),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        op_hs     = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Ready is suppressed while reset is held so no operand is
                // taken that the reset edge would immediately discard.
                if (rst_n && any_req) begin
                    req_ready[grant] = 1'b1;
                    op_hs            = 1'b1;
                    state_d          = MUL;
                end
            end
            MUL: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (op_hs) begin
                a_q  <= a_sel;
                b_q  <= b_sel;
                id_q <= grant;
            end
            if (state_q == MUL) begin
                rsp_data <= prod;
                rsp_id   <= id_q;
            end
            if (rsp_hs) begin
                // Requester after the one just served gets first look next time.
                ptr_q <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_fxp_mul_scheduler.sv
module tb_fxp_mul_scheduler;
    import fxp_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int BW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic [1:0]      rsp_id;
    logic            busy;
    logic [15:0]     op_count;

    fxp_mul_scheduler #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [15:0] a; logic [15:0] b; } op_t;
    typedef struct { int id; logic [31:0] prod; int t; } exp_t;

    op_t  opq[$];
    exp_t sbq[$];
    int   grant_log[$];
    int   resp_cyc[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_data;
    int          last_id;
    bit          rand_bp = 1'b0;

    // Reference model state: who may be granted next, whether an op is
    // outstanding, and how many have completed.
    int          ptr_m = 0;
    logic [15:0] cnt_m = '0;
    bit          in_flight = 1'b0;
    bit          first_seen = 1'b0;
    bit          hold_valid = 1'b0;
    bit          rst_low_prev = 1'b0;
    logic [31:0] hold_data;
    int          hold_id;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fx_mul(input logic [15:0] a, input logic [15:0] b);
        longint x, y;
        x = $signed(a);
        y = $signed(b);
        return 32'(x * y);
    endfunction

    function automatic int rr(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic push(input int id, input logic [15:0] a, input logic [15:0] b);
        op_t o;
        o.id = id; o.a = a; o.b = b;
        opq.push_back(o);
    endtask

    // Requesters: each presents its next queued op and holds it until accepted.
    initial begin
        logic [N-1:0] hs;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    for (int j = 0; j < opq.size(); j++) begin
                        if (opq[j].id == i) begin
                            req_a[i*AW +: AW] = opq[j].a;
                            req_b[i*BW +: BW] = opq[j].b;
                            req_valid[i]      = 1'b1;
                            opq.delete(j);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [N-1:0] exp_rdy;
        int           g;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (rst_low_prev) begin
                    chk("rst_rsp_valid", rsp_valid, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_req_ready", req_ready, 0);
                    chk("rst_op_count", op_count, 0);
                    chk("rst_rsp_data", rsp_data, 0);
                    chk("rst_rsp_id", rsp_id, 0);
                end
                sbq.delete();
                in_flight    = 1'b0;
                ptr_m        = 0;
                cnt_m        = '0;
                first_seen   = 1'b0;
                hold_valid   = 1'b0;
                rst_low_prev = 1'b1;
            end else begin
                rst_low_prev = 1'b0;
                exp_rdy = '0;
                g = rr(req_valid, ptr_m);
                if (!in_flight && g >= 0) exp_rdy[g] = 1'b1;
                chk("req_ready", req_ready, exp_rdy);
                chk("busy", busy, in_flight);
                chk("op_count", op_count, cnt_m);
                if (hold_valid) begin
                    chk("hold_valid", rsp_valid, 1);
                    chk("hold_data", rsp_data, hold_data);
                    chk("hold_id", rsp_id, hold_id);
                end
                hold_valid = 1'b0;
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        if (!first_seen) chk("latency", cyc, sbq[0].t + 2);
                        first_seen = 1'b1;
                        if (rsp_ready) begin
                            e = sbq.pop_front();
                            chk("rsp_data", rsp_data, e.prod);
                            chk("rsp_id", rsp_id, e.id);
                            last_data  = rsp_data;
                            last_id    = rsp_id;
                            resp_cyc.push_back(cyc);
                            cnt_m      = cnt_m + 16'd1;
                            ptr_m      = (e.id + 1) % N;
                            in_flight  = 1'b0;
                            first_seen = 1'b0;
                        end else begin
                            hold_valid = 1'b1;
                            hold_data  = rsp_data;
                            hold_id    = rsp_id;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.id   = i;
                        e.prod = fx_mul(req_a[i*AW +: AW], req_b[i*BW +: BW]);
                        e.t    = cyc;
                        sbq.push_back(e);
                        grant_log.push_back(i);
                        in_flight = 1'b1;
                    end
                end
            end
        end
    end

    // Random back-pressure, active only in the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drain(input int maxc);
        int c;
        c = 0;
        while ((opq.size() != 0 || req_valid != '0 || sbq.size() != 0 || busy || rsp_valid) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        if (c >= maxc) begin
            errors++;
            $display("FAIL drain_timeout: waited %0d cycles", c);
        end
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin
        int c;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed products.
        push(0, 16'h0100, 16'h0200); drain(100);
        chk("t_req0_data", last_data, 32'h00020000);
        chk("t_req0_id", last_id, 0);
        chk("t_req0_count", op_count, 16'd1);
        push(1, 16'hFF00, 16'h0200); drain(100);
        chk("t_req1_data", last_data, 32'hFFFE0000);
        chk("t_req1_id", last_id, 1);
        push(2, 16'h8000, 16'h4000); drain(100);
        chk("t_req2_data", last_data, 32'hE0000000);
        chk("t_req2_id", last_id, 2);
        push(3, 16'h00A0, 16'h00C0); drain(100);
        chk("t_req3_data", last_data, 32'h00007800);
        chk("t_req3_id", last_id, 3);

        // All requesters valid out of reset: round-robin order, 3-cycle spacing.
        @(posedge clk); #1 rst_n = 1'b0;
        push(0, rnd_op(), rnd_op()); push(1, rnd_op(), rnd_op());
        push(2, rnd_op(), rnd_op()); push(3, rnd_op(), rnd_op());
        push(0, rnd_op(), rnd_op());
        repeat (3) @(posedge clk);
        grant_log.delete(); resp_cyc.delete();
        #1 rst_n = 1'b1;
        drain(200);
        chk("rr_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            chk("rr_order0", grant_log[0], 0);
            chk("rr_order1", grant_log[1], 1);
            chk("rr_order2", grant_log[2], 2);
            chk("rr_order3", grant_log[3], 3);
            chk("rr_order4", grant_log[4], 0);
        end
        if (resp_cyc.size() == 5)
            for (int k = 1; k < 5; k++) chk("rr_spacing", resp_cyc[k] - resp_cyc[k-1], 3);

        // Back-pressure in RESP with a competing requester.
        rsp_ready = 1'b0;
        grant_log.delete();
        push(3, rnd_op(), rnd_op());
        c = 0;
        while (!rsp_valid && c < 50) begin @(negedge clk); c++; end
        chk("bp_reach_resp", rsp_valid, 1);
        push(1, rnd_op(), rnd_op());
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_no_grant", req_ready, 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        drain(100);
        chk("bp_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("bp_first", grant_log[0], 3);
            chk("bp_second", grant_log[1], 1);
        end

        // Reset while an op sits in MUL.
        push(1, rnd_op(), rnd_op());
        c = 0;
        do begin @(negedge clk); c++; end while (!req_ready[1] && c < 50);
        chk("mid_grant1", req_ready[1], 1);
        @(posedge clk); #1 rst_n = 1'b0;
        push(2, 16'h0300, 16'h0100);
        repeat (2) @(posedge clk);
        grant_log.delete();
        #1 rst_n = 1'b1;
        drain(100);
        chk("mid_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
        chk("mid_rsp_id", last_id, 2);
        chk("mid_rsp_data", last_data, 32'h00030000);
        chk("mid_op_count", op_count, 16'd1);

        // op_count wrap.
        @(posedge clk);
        #1 force dut.cnt_q = 16'hFFFF;
        cnt_m = 16'hFFFF;
        #1 release dut.cnt_q;
        @(negedge clk);
        chk("preload", op_count, 16'hFFFF);
        push(0, rnd_op(), rnd_op());
        drain(100);
        chk("wrap", op_count, 16'h0000);

        // Random traffic with random back-pressure.
        rand_bp = 1'b1;
        for (int k = 0; k < 150; k++) begin
            push(int'($urandom_range(0, N-1)), rnd_op(), rnd_op());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
        end
        drain(5000);
        rand_bp = 1'b0;
        @(posedge clk); #1 rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        summary();
        $finish;
    end

endmodule
